// File: rtl/cfg_pkg.sv
// Build-time configuration for the order-book update stage.
//   ENTRIES_N    : number of table slots
//   IS_BID_TABLE : 1 = index 0 holds the highest key, 0 = the lowest key
//   POS_BITS     : width of an insert position (0..ENTRIES_N inclusive)
package cfg_pkg;

   localparam int ENTRIES_N    = 4;
   localparam bit IS_BID_TABLE = 1'b1;
   localparam int POS_BITS     = $clog2(ENTRIES_N + 1);

endpackage

// File: rtl/v_pkg.sv
// Shared types for the order-book update stage: key/volume widths,
// command opcodes, response status codes and the shifter operation.
package v_pkg;

   localparam int KEY_BITS    = 16;
   localparam int VOLUME_BITS = 16;

   typedef logic [KEY_BITS-1:0]    key_t;
   typedef logic [VOLUME_BITS-1:0] volume_t;

   typedef enum logic [2:0] {
      OP_NOP = 3'd0,
      OP_CLR = 3'd1,
      OP_ADD = 3'd2,
      OP_DEL = 3'd3,
      OP_REP = 3'd4
   } op_t;

   typedef enum logic [2:0] {
      ST_OK           = 3'd0,
      ST_SAT          = 3'd1,
      ST_EVICT        = 3'd2,
      ST_ERR_FULL     = 3'd3,
      ST_ERR_NOTFOUND = 3'd4
   } status_t;

   // Table edit applied by the shifter in a given cycle.
   typedef enum logic [2:0] {
      SHF_HOLD = 3'd0,
      SHF_CLR  = 3'd1,
      SHF_UPD  = 3'd2,
      SHF_INS  = 3'd3,
      SHF_DEL  = 3'd4
   } shf_op_t;

endpackage

// File: rtl/v_pipe_update_shf.sv
// Combinational next-state of the sorted table.
//   op_i         : edit to apply (hold, clear, update, insert, delete)
//   pos_i        : insert position (entries at pos_i and above move up one)
//   sel_i        : one-hot slot for update / delete (entries above move down)
//   key_i, vol_i : key/volume written by insert, volume written by update
//   vld_i/keys_i/vols_i : current table; vld_o/keys_o/vols_o : next table
module v_pipe_update_shf
   import cfg_pkg::*;
   import v_pkg::*;
(
   input  shf_op_t                       op_i,
   input  logic [POS_BITS-1:0]           pos_i,
   input  logic [ENTRIES_N-1:0]          sel_i,
   input  key_t                          key_i,
   input  volume_t                       vol_i,
   input  logic [ENTRIES_N-1:0]          vld_i,
   input  key_t    [ENTRIES_N-1:0]       keys_i,
   input  volume_t [ENTRIES_N-1:0]       vols_i,
   output logic [ENTRIES_N-1:0]          vld_o,
   output key_t    [ENTRIES_N-1:0]       keys_o,
   output volume_t [ENTRIES_N-1:0]       vols_o
);

   logic at_or_above;

   always_comb begin
      vld_o       = vld_i;
      keys_o      = keys_i;
      vols_o      = vols_i;
      at_or_above = 1'b0;
      case (op_i)
         SHF_CLR: vld_o = '0;
         SHF_UPD: begin
            for (int i = 0; i < ENTRIES_N; i++) begin
               if (sel_i[i]) vols_o[i] = vol_i;
            end
         end
         SHF_INS: begin
            // Whatever sat in the last slot falls off the end.
            if (pos_i == '0) begin
               vld_o[0]  = 1'b1;
               keys_o[0] = key_i;
               vols_o[0] = vol_i;
            end
            for (int i = 1; i < ENTRIES_N; i++) begin
               if (POS_BITS'(i) == pos_i) begin
                  vld_o[i]  = 1'b1;
                  keys_o[i] = key_i;
                  vols_o[i] = vol_i;
               end else if (POS_BITS'(i) > pos_i) begin
                  vld_o[i]  = vld_i[i-1];
                  keys_o[i] = keys_i[i-1];
                  vols_o[i] = vols_i[i-1];
               end
            end
         end
         SHF_DEL: begin
            for (int i = 0; i < ENTRIES_N - 1; i++) begin
               at_or_above = at_or_above | sel_i[i];
               if (at_or_above) begin
                  vld_o[i]  = vld_i[i+1];
                  keys_o[i] = keys_i[i+1];
                  vols_o[i] = vols_i[i+1];
               end
            end
            // Top slot keeps its stale key/volume, only the valid bit drops.
            vld_o[ENTRIES_N-1] = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/v_pipe_update_exe.sv
// Execute stage of the order-book pipeline: applies one command per cycle
// to the registered sorted table, using match/rank flags produced by the
// compare stage against the same registered state.
//   clk, rst (sync, active-high)
//   i_pipe_*            : command (valid, op, key, volume)
//   i_match_*, i_mask_cmp : compare-stage hit/full flags, one-hot match, rank mask
//   o_stcur_*           : registered table (valid, keys, volumes)
//   o_rsp_*             : registered response (valid, status, echoed key)
//   o_evict_*           : entry pushed out of a full table
// Macro V_PIPE_UPDATE_EVICT_EN: a miss on a full table inserts and evicts the
// last entry instead of failing; it also adds the o_evict_* ports.
module v_pipe_update_exe
   import cfg_pkg::*;
   import v_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_pipe_vld,
   input  op_t                           i_pipe_op,
   input  key_t                          i_pipe_key_r,
   input  volume_t                       i_pipe_volume,
   input  logic                          i_match_hit,
   input  logic                          i_match_full,
   input  logic [ENTRIES_N-1:0]          i_match_sel,
   input  logic [ENTRIES_N-1:0]          i_mask_cmp,
   output logic [ENTRIES_N-1:0]          o_stcur_vld_r,
   output key_t    [ENTRIES_N-1:0]       o_stcur_keys_r,
   output volume_t [ENTRIES_N-1:0]       o_stcur_volumes_r,
`ifdef V_PIPE_UPDATE_EVICT_EN
   output logic                          o_evict_vld_r,
   output key_t                          o_evict_key_r,
   output volume_t                       o_evict_volume_r,
`endif
   output logic                          o_rsp_vld_r,
   output status_t                       o_rsp_status_r,
   output key_t                          o_rsp_key_r
);

   logic [ENTRIES_N-1:0]    vld_q, vld_d;
   key_t    [ENTRIES_N-1:0] keys_q, keys_d;
   volume_t [ENTRIES_N-1:0] vols_q, vols_d;
   logic                    rsp_vld_q, rsp_vld_d;
   status_t                 rsp_status_q, rsp_status_d;
   key_t                    rsp_key_q;

   shf_op_t                 shf_op, miss_op;
   status_t                 miss_status;
   volume_t                 upd_vol, cur_vol;
   logic [POS_BITS-1:0]     ins_pos;
   logic [VOLUME_BITS:0]    sum;

   // The rank mask is unary, so its popcount is the insert position.
   always_comb begin
      ins_pos = '0;
      cur_vol = '0;
      for (int i = 0; i < ENTRIES_N; i++) begin
         ins_pos = ins_pos + POS_BITS'(i_mask_cmp[i]);
         if (i_match_sel[i]) cur_vol = cur_vol | vols_q[i];
      end
   end

   assign sum = {1'b0, cur_vol} + {1'b0, i_pipe_volume};

   // Shared by ADD miss and REP miss.
   always_comb begin
      miss_op     = SHF_HOLD;
      miss_status = ST_ERR_FULL;
      if (!i_match_full) begin
         miss_op     = SHF_INS;
         miss_status = ST_OK;
      end
`ifdef V_PIPE_UPDATE_EVICT_EN
      else if (ins_pos < POS_BITS'(ENTRIES_N)) begin
         miss_op     = SHF_INS;
         miss_status = ST_EVICT;
      end
`endif
   end

   always_comb begin
      shf_op       = SHF_HOLD;
      upd_vol      = i_pipe_volume;
      rsp_vld_d    = 1'b0;
      rsp_status_d = ST_OK;
      if (i_pipe_vld) begin
         case (i_pipe_op)
            OP_CLR: begin
               shf_op    = SHF_CLR;
               rsp_vld_d = 1'b1;
            end
            OP_ADD: begin
               rsp_vld_d = 1'b1;
               if (i_match_hit) begin
                  shf_op = SHF_UPD;
                  if (sum[VOLUME_BITS]) begin
                     upd_vol      = '1;
                     rsp_status_d = ST_SAT;
                  end else begin
                     upd_vol = sum[VOLUME_BITS-1:0];
                  end
               end else begin
                  shf_op       = miss_op;
                  rsp_status_d = miss_status;
               end
            end
            OP_DEL: begin
               rsp_vld_d = 1'b1;
               if (i_match_hit) begin
                  if (cur_vol <= i_pipe_volume) begin
                     shf_op = SHF_DEL;
                  end else begin
                     shf_op  = SHF_UPD;
                     upd_vol = cur_vol - i_pipe_volume;
                  end
               end else begin
                  rsp_status_d = ST_ERR_NOTFOUND;
               end
            end
            OP_REP: begin
               rsp_vld_d = 1'b1;
               if (i_match_hit) begin
                  shf_op = (i_pipe_volume == '0) ? SHF_DEL : SHF_UPD;
               end else begin
                  shf_op       = miss_op;
                  rsp_status_d = miss_status;
               end
            end
            default: ;
         endcase
      end
   end

   v_pipe_update_shf u_shf (
      .op_i   (shf_op),
      .pos_i  (ins_pos),
      .sel_i  (i_match_sel),
      .key_i  (i_pipe_key_r),
      .vol_i  (upd_vol),
      .vld_i  (vld_q),
      .keys_i (keys_q),
      .vols_i (vols_q),
      .vld_o  (vld_d),
      .keys_o (keys_d),
      .vols_o (vols_d)
   );

`ifdef V_PIPE_UPDATE_EVICT_EN
   logic    evict_d;
   logic    evict_vld_q;
   key_t    evict_key_q;
   volume_t evict_vol_q;

   // Inserting into a full table always pushes out the last slot.
   assign evict_d = (shf_op == SHF_INS) && i_match_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         evict_vld_q <= 1'b0;
      end else begin
         evict_vld_q <= evict_d;
         if (evict_d) begin
            evict_key_q <= keys_q[ENTRIES_N-1];
            evict_vol_q <= vols_q[ENTRIES_N-1];
         end
      end
   end

   assign o_evict_vld_r    = evict_vld_q;
   assign o_evict_key_r    = evict_key_q;
   assign o_evict_volume_r = evict_vol_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q     <= '0;
         rsp_vld_q <= 1'b0;
      end else begin
         vld_q     <= vld_d;
         keys_q    <= keys_d;
         vols_q    <= vols_d;
         rsp_vld_q <= rsp_vld_d;
         if (rsp_vld_d) begin
            rsp_status_q <= rsp_status_d;
            rsp_key_q    <= i_pipe_key_r;
         end
      end
   end

   assign o_stcur_vld_r     = vld_q;
   assign o_stcur_keys_r    = keys_q;
   assign o_stcur_volumes_r = vols_q;
   assign o_rsp_vld_r       = rsp_vld_q;
   assign o_rsp_status_r    = rsp_status_q;
   assign o_rsp_key_r       = rsp_key_q;

endmodule

// File: tb/tb_v_pipe_update_exe.sv
// Bench for v_pipe_update_exe: acts as the compare stage from its own
// reference table, queues the expected response/state for every accepted
// command and checks them when the response appears one cycle later.
module tb_v_pipe_update_exe;
   import cfg_pkg::*;
   import v_pkg::*;

   localparam int N = ENTRIES_N;

   logic                 clk;
   logic                 rst;
   logic                 i_pipe_vld;
   op_t                  i_pipe_op;
   key_t                 i_pipe_key_r;
   volume_t              i_pipe_volume;
   logic                 i_match_hit;
   logic                 i_match_full;
   logic [N-1:0]         i_match_sel;
   logic [N-1:0]         i_mask_cmp;
   logic [N-1:0]         o_stcur_vld_r;
   key_t    [N-1:0]      o_stcur_keys_r;
   volume_t [N-1:0]      o_stcur_volumes_r;
   logic                 o_rsp_vld_r;
   status_t              o_rsp_status_r;
   key_t                 o_rsp_key_r;
`ifdef V_PIPE_UPDATE_EVICT_EN
   logic                 o_evict_vld_r;
   key_t                 o_evict_key_r;
   volume_t              o_evict_volume_r;
`endif

   v_pipe_update_exe dut (
      .clk               (clk),
      .rst               (rst),
      .i_pipe_vld        (i_pipe_vld),
      .i_pipe_op         (i_pipe_op),
      .i_pipe_key_r      (i_pipe_key_r),
      .i_pipe_volume     (i_pipe_volume),
      .i_match_hit       (i_match_hit),
      .i_match_full      (i_match_full),
      .i_match_sel       (i_match_sel),
      .i_mask_cmp        (i_mask_cmp),
      .o_stcur_vld_r     (o_stcur_vld_r),
      .o_stcur_keys_r    (o_stcur_keys_r),
      .o_stcur_volumes_r (o_stcur_volumes_r),
`ifdef V_PIPE_UPDATE_EVICT_EN
      .o_evict_vld_r     (o_evict_vld_r),
      .o_evict_key_r     (o_evict_key_r),
      .o_evict_volume_r  (o_evict_volume_r),
`endif
      .o_rsp_vld_r       (o_rsp_vld_r),
      .o_rsp_status_r    (o_rsp_status_r),
      .o_rsp_key_r       (o_rsp_key_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      key_t    key;
      volume_t vol;
   } ent_t;

   typedef struct {
      status_t      st;
      key_t         key;
      logic [N-1:0] vld;
      logic [127:0] keys;
      logic [127:0] vols;
      logic         ev;
      key_t         ev_key;
      volume_t      ev_vol;
   } exp_t;

   ent_t tbl[$];
   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic bit better(input key_t a, input key_t b);
      return IS_BID_TABLE ? (a > b) : (a < b);
   endfunction

   task automatic model_miss(input key_t key, input volume_t vol, input int pos, inout exp_t e);
      ent_t n;
      n.key = key;
      n.vol = vol;
      if (tbl.size() < N) begin
         tbl.insert(pos, n);
      end else begin
`ifdef V_PIPE_UPDATE_EVICT_EN
         if (pos < N) begin
            e.ev     = 1'b1;
            e.ev_key = tbl[N-1].key;
            e.ev_vol = tbl[N-1].vol;
            void'(tbl.pop_back());
            tbl.insert(pos, n);
            e.st = ST_EVICT;
         end else begin
            e.st = ST_ERR_FULL;
         end
`else
         e.st = ST_ERR_FULL;
`endif
      end
   endtask

   // Drives one valid command with compare-stage flags derived from the
   // reference table, then applies the command to the reference table.
   task automatic drive(input op_t op, input key_t key, input volume_t vol);
      int            idx;
      int            pos;
      logic [N-1:0]  sel;
      logic [N-1:0]  mask;
      logic [16:0]   s;
      exp_t          e;
      @(negedge clk);
      idx  = -1;
      pos  = 0;
      sel  = '0;
      mask = '0;
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].key == key) begin
            idx    = i;
            sel[i] = 1'b1;
         end
         if (better(tbl[i].key, key)) begin
            mask[i] = 1'b1;
            pos++;
         end
      end
      i_pipe_vld    = 1'b1;
      i_pipe_op     = op;
      i_pipe_key_r  = key;
      i_pipe_volume = vol;
      i_match_hit   = (idx >= 0);
      i_match_full  = (tbl.size() == N);
      i_match_sel   = sel;
      i_mask_cmp    = mask;
      e.st     = ST_OK;
      e.key    = key;
      e.ev     = 1'b0;
      e.ev_key = '0;
      e.ev_vol = '0;
      case (op)
         OP_CLR: tbl.delete();
         OP_ADD: begin
            if (idx >= 0) begin
               s = {1'b0, tbl[idx].vol} + {1'b0, vol};
               if (s > 17'h0FFFF) begin
                  tbl[idx].vol = 16'hFFFF;
                  e.st = ST_SAT;
               end else begin
                  tbl[idx].vol = s[15:0];
               end
            end else begin
               model_miss(key, vol, pos, e);
            end
         end
         OP_DEL: begin
            if (idx < 0) e.st = ST_ERR_NOTFOUND;
            else if (tbl[idx].vol <= vol) tbl.delete(idx);
            else tbl[idx].vol = tbl[idx].vol - vol;
         end
         OP_REP: begin
            if (idx < 0) model_miss(key, vol, pos, e);
            else if (vol == 0) tbl.delete(idx);
            else tbl[idx].vol = vol;
         end
         default: ;
      endcase
      if (op != OP_NOP) begin
         e.vld  = '0;
         e.keys = '0;
         e.vols = '0;
         for (int i = 0; i < tbl.size(); i++) begin
            e.vld[i] = 1'b1;
            e.keys[i*KEY_BITS +: KEY_BITS]       = tbl[i].key;
            e.vols[i*VOLUME_BITS +: VOLUME_BITS] = tbl[i].vol;
         end
         sb.push_back(e);
      end
   endtask

   // Invalid cycle carrying an ADD opcode that must be ignored.
   task automatic idle();
      @(negedge clk);
      i_pipe_vld   = 1'b0;
      i_pipe_op    = OP_ADD;
      i_match_hit  = 1'b0;
      i_match_full = 1'b0;
      i_mask_cmp   = '0;
      i_match_sel  = '0;
   endtask

   always @(posedge clk) begin
      logic [127:0] ak;
      logic [127:0] av;
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         ak = '0;
         av = '0;
         for (int i = 0; i < N; i++) begin
            if (mon_e.vld[i]) begin
               ak[i*KEY_BITS +: KEY_BITS]       = o_stcur_keys_r[i];
               av[i*VOLUME_BITS +: VOLUME_BITS] = o_stcur_volumes_r[i];
            end
         end
         check_eq("rsp_vld", 128'(o_rsp_vld_r), 128'(1'b1));
         check_eq("rsp_status", 128'(o_rsp_status_r), 128'(mon_e.st));
         check_eq("rsp_key", 128'(o_rsp_key_r), 128'(mon_e.key));
         check_eq("stcur_vld", 128'(o_stcur_vld_r), 128'(mon_e.vld));
         check_eq("stcur_keys", ak, mon_e.keys);
         check_eq("stcur_vols", av, mon_e.vols);
`ifdef V_PIPE_UPDATE_EVICT_EN
         check_eq("evict_vld", 128'(o_evict_vld_r), 128'(mon_e.ev));
         if (mon_e.ev) begin
            check_eq("evict_key", 128'(o_evict_key_r), 128'(mon_e.ev_key));
            check_eq("evict_vol", 128'(o_evict_volume_r), 128'(mon_e.ev_vol));
         end
`endif
      end else if (o_rsp_vld_r) begin
         check_eq("rsp_spurious", 128'(o_rsp_vld_r), 128'(1'b0));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      rst           = 1'b1;
      i_pipe_vld    = 1'b0;
      i_pipe_op     = OP_NOP;
      i_pipe_key_r  = '0;
      i_pipe_volume = '0;
      i_match_hit   = 1'b0;
      i_match_full  = 1'b0;
      i_match_sel   = '0;
      i_mask_cmp    = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_vld", 128'(o_stcur_vld_r), 128'(0));
      check_eq("reset_rsp_vld", 128'(o_rsp_vld_r), 128'(0));
      rst = 1'b0;

      // Sorted inserts into an empty table.
      drive(OP_ADD, 16'd10, 16'd5);
      drive(OP_ADD, 16'd30, 16'd5);
      drive(OP_ADD, 16'd20, 16'd5);
      // Remove from the middle, then a miss.
      drive(OP_DEL, 16'd20, 16'd5);
      drive(OP_DEL, 16'd99, 16'd5);
      drive(OP_NOP, 16'd30, 16'd1);
      @(posedge clk);
      #1;
      check_eq("nop_rsp_vld", 128'(o_rsp_vld_r), 128'(0));
      idle();
      // Partial delete, replace, saturating add.
      drive(OP_DEL, 16'd30, 16'd2);
      drive(OP_REP, 16'd30, 16'hFFF0);
      drive(OP_ADD, 16'd30, 16'h0020);
      // Fill the table, then full-table misses at the front and the back.
      drive(OP_ADD, 16'd20, 16'd5);
      drive(OP_ADD, 16'd5, 16'd5);
      drive(OP_ADD, 16'd40, 16'd7);
      drive(OP_ADD, 16'd1, 16'd7);
      drive(OP_REP, 16'd25, 16'd3);
      // Underflowing delete removes the entry; REP zero removes too.
      drive(OP_DEL, 16'd10, 16'd100);
      drive(OP_REP, 16'd20, 16'd0);
      drive(OP_CLR, 16'd0, 16'd0);
      drive(OP_ADD, 16'd50, 16'd1);
      drive(OP_ADD, 16'd60, 16'd1);

      // Reset with a valid ADD on the same cycle: the command is dropped.
      @(negedge clk);
      rst           = 1'b1;
      i_pipe_vld    = 1'b1;
      i_pipe_op     = OP_ADD;
      i_pipe_key_r  = 16'd70;
      i_pipe_volume = 16'd1;
      i_match_hit   = 1'b0;
      i_match_full  = 1'b0;
      i_match_sel   = '0;
      i_mask_cmp    = '0;
      tbl.delete();
      @(posedge clk);
      #1;
      check_eq("midrst_vld", 128'(o_stcur_vld_r), 128'(0));
      check_eq("midrst_rsp_vld", 128'(o_rsp_vld_r), 128'(0));
      rst = 1'b0;
      drive(OP_ADD, 16'd7, 16'd1);

      for (int k = 0; k < 80; k++) begin
         r = $urandom_range(0, 9);
         case (r)
            0: idle();
            1: drive(OP_NOP, key_t'($urandom_range(1, 9)), 16'd1);
            2: drive(($urandom_range(0, 3) == 0) ? OP_CLR : OP_ADD,
                     key_t'($urandom_range(1, 9)), volume_t'($urandom_range(0, 6)));
            3, 4, 5: drive(OP_ADD, key_t'($urandom_range(1, 9)), volume_t'($urandom_range(0, 6)));
            6, 7: drive(OP_DEL, key_t'($urandom_range(1, 9)), volume_t'($urandom_range(0, 6)));
            default: drive(OP_REP, key_t'($urandom_range(1, 9)), volume_t'($urandom_range(0, 6)));
         endcase
      end

      repeat (3) idle();
      @(posedge clk);
      #2;
      check_eq("rsp_pending", 128'(sb.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
